// File: rtl/pwm_fade_seq_if.sv
// Write port of the 8-channel pwm peripheral: strobe, register address and data.
// The fade sequencer drives it as master; pwm (or a bus mux) sits on the slave side.
interface pwm_fade_seq_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          m_wr;
    logic [AW-1:0] m_adrs;
    logic [DW-1:0] m_din;

    modport master (output m_wr, output m_adrs, output m_din);
    modport slave  (input  m_wr, input  m_adrs, input  m_din);
endinterface

// File: rtl/pwm_fade_seq.sv
// Duty-cycle ramp sequencer: programs one pwm channel, then steps its duty register
// every interval clocks until the end duty is reached.
module pwm_fade_seq #(
    parameter int NCH    = 8,
    parameter int STRIDE = 12,
    parameter int AW     = 7,
    parameter int DW     = 32,
    parameter int TW     = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [2:0]    ch,
    input  logic [DW-1:0] period,
    input  logic [DW-1:0] duty_start,
    input  logic [DW-1:0] duty_end,
    input  logic [15:0]   step,
    input  logic [TW-1:0] interval,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] cur_duty,
    pwm_fade_seq_if.master bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] W_PER  = 3'd1;
    localparam logic [2:0] W_DUTY = 3'd2;
    localparam logic [2:0] W_EN   = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] W_DIS  = 3'd6;

    localparam logic [AW-1:0] STR    = AW'(STRIDE);
    localparam logic [AW-1:0] LASTCH = AW'(NCH - 1);
    localparam logic [AW-1:0] OFS_PER  = AW'(4);
    localparam logic [AW-1:0] OFS_DUTY = AW'(8);

    logic [2:0]    state, nxt;
    logic [AW-1:0] base_q, base_in, ch_ext, ch_c;
    logic [DW-1:0] duty_q, dend_q, nd, duty_wr;
    logic [15:0]   step_q;
    logic [TW-1:0] ivl_q, cnt;
    logic          up_q, en_q, at_end;
    logic [DW:0]   sum, diff, dend_ext, step_ext;

    assign ch_ext  = AW'(ch);
    assign ch_c    = (ch_ext > LASTCH) ? LASTCH : ch_ext;
    assign base_in = ch_c * STR;
    assign at_end  = (duty_q == dend_q);

    // Next duty is formed one bit wider than the data path so the step can never wrap
    always_comb begin
        step_ext = {{(DW + 1 - 16){1'b0}}, step_q};
        dend_ext = {1'b0, dend_q};
        sum      = {1'b0, duty_q} + step_ext;
        diff     = {1'b0, duty_q} - step_ext;
        nd       = dend_q;
        if (step_q != 16'd0) begin
            if (up_q) begin
                if (sum < dend_ext) nd = sum[DW-1:0];
            end else begin
                if (!diff[DW] && diff > dend_ext) nd = diff[DW-1:0];
            end
        end
        duty_wr = (state == WAIT) ? nd : duty_q;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = W_PER;
            W_PER:   nxt = W_DUTY;
            W_DUTY:  nxt = !en_q ? W_EN : (at_end ? DONE : WAIT);
            W_EN:    nxt = at_end ? DONE : WAIT;
            WAIT:    if (cnt == '0) nxt = W_DUTY;
            DONE:    nxt = IDLE;
            W_DIS:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort && state != IDLE && state != W_DIS) nxt = W_DIS;
    end

    // Bus outputs are registered from the next state so each write lands in its state's cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            cur_duty    <= '0;
            bus.m_wr    <= 1'b0;
            bus.m_adrs  <= '0;
            bus.m_din   <= '0;
            base_q      <= '0;
            duty_q      <= '0;
            dend_q      <= '0;
            step_q      <= '0;
            ivl_q       <= '0;
            cnt         <= '0;
            up_q        <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state    <= nxt;
            busy     <= (nxt != IDLE);
            done     <= (nxt == DONE);
            bus.m_wr <= 1'b0;

            if (state == IDLE && start) begin
                base_q <= base_in;
                duty_q <= duty_start;
                dend_q <= duty_end;
                step_q <= step;
                ivl_q  <= (interval == '0) ? TW'(1) : interval;
                up_q   <= (duty_end >= duty_start);
                en_q   <= 1'b0;
            end

            if (nxt == WAIT && state != WAIT)
                cnt <= ivl_q - TW'(1);
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - TW'(1);

            case (nxt)
                W_PER: begin
                    bus.m_wr   <= 1'b1;
                    bus.m_adrs <= base_in + OFS_PER;
                    bus.m_din  <= period;
                end
                W_DUTY: begin
                    bus.m_wr   <= 1'b1;
                    bus.m_adrs <= base_q + OFS_DUTY;
                    bus.m_din  <= duty_wr;
                    cur_duty   <= duty_wr;
                    duty_q     <= duty_wr;
                end
                W_EN: begin
                    bus.m_wr   <= 1'b1;
                    bus.m_adrs <= base_q;
                    bus.m_din  <= DW'(1);
                    en_q       <= 1'b1;
                end
                W_DIS: begin
                    bus.m_wr   <= 1'b1;
                    bus.m_adrs <= base_q;
                    bus.m_din  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_fade_seq.sv
// Scoreboard bench for pwm_fade_seq: expected pwm writes are queued with the stimulus
// and a negedge monitor pops and compares each write as it appears on the bus.
module tb_pwm_fade_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [2:0]  ch;
    logic [31:0] period;
    logic [31:0] duty_start;
    logic [31:0] duty_end;
    logic [15:0] step;
    logic [23:0] interval;
    logic        busy;
    logic        done;
    logic [31:0] cur_duty;

    pwm_fade_seq_if #(.AW(7), .DW(32)) bus ();

    pwm_fade_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .ch         (ch),
        .period     (period),
        .duty_start (duty_start),
        .duty_end   (duty_end),
        .step       (step),
        .interval   (interval),
        .busy       (busy),
        .done       (done),
        .cur_duty   (cur_duty),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  adrs;
        logic [31:0] din;
        int          gap;
    } wr_t;

    wr_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  last_wr  = 0;
    int  extra_wr = 0;
    int  done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectWrite(input logic [6:0] a, input logic [31:0] d, input int gap);
        wr_t w;
        w.adrs = a;
        w.din  = d;
        w.gap  = gap;
        q.push_back(w);
    endtask

    // Monitor: every bus write is matched against the head of the scoreboard
    always @(negedge clk) begin
        if (bus.m_wr) begin
            if (q.size() == 0) begin
                extra_wr++;
            end else begin
                wr_t w;
                w = q.pop_front();
                checkOutput("wr_adrs", {25'd0, bus.m_adrs}, {25'd0, w.adrs});
                checkOutput("wr_din", bus.m_din, w.din);
                if (w.gap != 0) checkOutput("wr_gap", cyc - last_wr, w.gap);
            end
            last_wr = cyc;
        end
        if (done) done_cnt++;
    end

    task automatic applyStimulus(input logic [2:0] c, input logic [31:0] p, input logic [31:0] ds,
                                 input logic [31:0] de, input logic [15:0] st, input logic [23:0] iv);
        @(negedge clk);
        ch = c; period = p; duty_start = ds; duty_end = de; step = st; interval = iv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ch = 3'd5; period = 32'hDEAD; duty_start = 32'h77; duty_end = 32'h99;
        step = 16'h3; interval = 24'd9;
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic waitDone(input string name, input logic [31:0] exp_duty, input int limit);
        int found = 0;
        for (int k = 0; k < limit && found == 0; k++) begin
            @(negedge clk);
            if (done) found = 1;
        end
        checkOutput({name, "_done_seen"}, found, 1);
        if (found != 0) begin
            checkOutput({name, "_done_lat"}, cyc - last_wr, 1);
            checkOutput({name, "_busy_in_done"}, {31'd0, busy}, 32'd1);
            checkOutput({name, "_cur_duty"}, cur_duty, exp_duty);
            @(negedge clk);
            checkOutput({name, "_busy_after"}, {31'd0, busy}, 32'd0);
            checkOutput({name, "_done_after"}, {31'd0, done}, 32'd0);
        end
        checkOutput({name, "_queue_empty"}, q.size(), 0);
        checkOutput({name, "_no_extra_wr"}, extra_wr, 0);
    endtask

    task automatic runUpRamp(input string name);
        expectWrite(7'h10, 32'd20, 0);
        expectWrite(7'h14, 32'd2, 1);
        expectWrite(7'h0C, 32'd1, 1);
        expectWrite(7'h14, 32'd6, 4);
        expectWrite(7'h14, 32'd10, 4);
        applyStimulus(3'd1, 32'd20, 32'd2, 32'd10, 16'd4, 24'd3);
        waitDone(name, 32'd10, 40);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base_done;
        int found;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ch = '0; period = '0;
        duty_start = '0; duty_end = '0; step = '0; interval = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_m_wr", {31'd0, bus.m_wr}, 32'd0);
        checkOutput("rst_m_adrs", {25'd0, bus.m_adrs}, 32'd0);
        checkOutput("rst_m_din", bus.m_din, 32'd0);
        checkOutput("rst_cur_duty", cur_duty, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("idle_no_wr", extra_wr, 0);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        runUpRamp("up");

        // Down ramp with saturation at the end value
        expectWrite(7'h58, 32'd100, 0);
        expectWrite(7'h5C, 32'd10, 1);
        expectWrite(7'h54, 32'd1, 1);
        expectWrite(7'h5C, 32'd6, 3);
        expectWrite(7'h5C, 32'd2, 3);
        expectWrite(7'h5C, 32'd1, 3);
        base_done = done_cnt;
        applyStimulus(3'd7, 32'd100, 32'd10, 32'd1, 16'd4, 24'd2);
        waitDone("down", 32'd1, 40);
        checkOutput("down_one_done", done_cnt - base_done, 1);

        expectWrite(7'h04, 32'd50, 0);
        expectWrite(7'h08, 32'd5, 1);
        expectWrite(7'h00, 32'd1, 1);
        applyStimulus(3'd0, 32'd50, 32'd5, 32'd5, 16'd3, 24'd4);
        waitDone("equal", 32'd5, 20);

        expectWrite(7'h1C, 32'd60, 0);
        expectWrite(7'h20, 32'd2, 1);
        expectWrite(7'h18, 32'd1, 1);
        expectWrite(7'h20, 32'd10, 6);
        applyStimulus(3'd2, 32'd60, 32'd2, 32'd10, 16'd0, 24'd5);
        waitDone("step0", 32'd10, 30);

        expectWrite(7'h34, 32'd70, 0);
        expectWrite(7'h38, 32'd0, 1);
        expectWrite(7'h30, 32'd1, 1);
        expectWrite(7'h38, 32'd1, 2);
        expectWrite(7'h38, 32'd2, 2);
        expectWrite(7'h38, 32'd3, 2);
        applyStimulus(3'd4, 32'd70, 32'd0, 32'd3, 16'd1, 24'd0);
        waitDone("ivl0", 32'd3, 30);

        // Abort while waiting; a start during busy must be ignored
        expectWrite(7'h28, 32'd30, 0);
        expectWrite(7'h2C, 32'd0, 1);
        expectWrite(7'h24, 32'd1, 1);
        base_done = done_cnt;
        applyStimulus(3'd3, 32'd30, 32'd0, 32'd100, 16'd10, 24'd10);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abort_pre_queue", q.size(), 0);
        expectWrite(7'h24, 32'd0, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_m_wr", {31'd0, bus.m_wr}, 32'd1);
        @(negedge clk);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        repeat (15) @(negedge clk);
        checkOutput("abort_no_done", done_cnt - base_done, 0);
        checkOutput("abort_queue_empty", q.size(), 0);
        checkOutput("abort_no_extra_wr", extra_wr, 0);
        checkOutput("abort_cur_duty", cur_duty, 32'd0);

        // Reset landing on a ramp duty write
        expectWrite(7'h4C, 32'd40, 0);
        expectWrite(7'h50, 32'd0, 1);
        expectWrite(7'h48, 32'd1, 1);
        expectWrite(7'h50, 32'd10, 4);
        applyStimulus(3'd6, 32'd40, 32'd0, 32'd20, 16'd10, 24'd3);
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            @(negedge clk);
            if (bus.m_wr && bus.m_adrs == 7'h50 && bus.m_din == 32'd10) found = 1;
        end
        checkOutput("rstmid_wr_seen", found, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstmid_m_wr", {31'd0, bus.m_wr}, 32'd0);
        checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
        checkOutput("rstmid_cur_duty", cur_duty, 32'd0);
        repeat (8) @(negedge clk);
        checkOutput("rstmid_no_extra_wr", extra_wr, 0);
        runUpRamp("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
